// File: rtl/apb_pkg.sv
// Shared types for the APB3 requester: bus FSM states, response record, defaults.
// APB3 caps the data bus at 32 bits, so the response record is sized for that maximum.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned APB_MASTER_DEF_TIMEOUT = 16;
  localparam int unsigned APB_MAX_DATA_W         = 32;

  typedef struct packed {
    logic [APB_MAX_DATA_W-1:0] rdata;
    logic                      err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response port plus APB3 bus signals for the apb_master requester.
//
// Command handshake: a command transfers on a rising PCLK edge where cmd_valid
// and cmd_ready are both high; cmd_* are don't-care while cmd_ready is low.
// rsp_valid is a one-cycle pulse with no backpressure.
interface apb_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles and flags the cycle in which the wait budget runs out.
// Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    // r_count holds the number of ACCESS cycles already spent waiting.
    assign o_expire = i_enable && (r_count == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB3 requester: valid/ready command port to IDLE/SETUP/ACCESS bus transfers.
// Optional wait-state abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = APB_MASTER_DEF_TIMEOUT
) (
    input  logic             PCLK,
    input  logic             PRESET,
    apb_master_if.master     bus,
    output apb_state_t       o_dbg_state
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_t            r_state;
    apb_state_t            w_next_state;
    logic                  w_cmd_ready;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_expire;

    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    apb_rsp_t              r_rsp;

`ifdef APB_MASTER_TIMEOUT_EN
    logic w_wait_clear;
    logic w_wait_en;

    assign w_wait_clear = (r_state == SETUP);
    assign w_wait_en    = (r_state == ACCESS) && !bus.PREADY;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (PCLK),
        .rst      (PRESET),
        .i_clear  (w_wait_clear),
        .i_enable (w_wait_en),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_complete   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) w_next_state = SETUP;
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    w_cmd_ready  = 1'b1;
                    w_complete   = 1'b1;
                    // A waiting command chains straight into SETUP, keeping PSEL high.
                    w_next_state = bus.cmd_valid ? SETUP : IDLE;
                end else if (w_expire) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_accept = bus.cmd_valid && w_cmd_ready;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_wdata;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_rsp_valid <= w_complete || w_expire;
            if (w_complete) begin
                r_rsp.err   <= bus.PSLVERR;
                r_rsp.rdata <= (!r_pwrite && !bus.PSLVERR) ? APB_MAX_DATA_W'(bus.PRDATA) : '0;
            end else if (w_expire) begin
                r_rsp.err   <= 1'b1;
                r_rsp.rdata <= '0;
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.PSEL      = (r_state != IDLE);
    assign bus.PENABLE   = (r_state == ACCESS);
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp.err;
    assign bus.rsp_rdata = r_rsp.rdata[DATA_WIDTH-1:0];
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: random slave timing against a transaction-level model.
// Timeout scenario adapts to APB_MASTER_TIMEOUT_EN.
module tb_apb_master;
  import apb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 4;
  localparam int INF = 1000;

  logic       PCLK = 1'b0;
  logic       PRESET;
  apb_state_t dbg_state;

  apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic          err;
  } xfer_t;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [DW:0]   exp_q[$];
  int            exp_cyc_q[$];
  xfer_t         sl_q[$];
  int            sl_cnt  = 0;
  bit            sl_done = 1'b0;
  logic [DW-1:0] slave_mem[logic [AW-1:0]];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  bit            tr_psel[int];
  bit            tr_pen[int];

  int            d_waits  = 0;
  logic          d_err    = 1'b0;
  int            acc_cycle = 0;
  bit            accepted  = 1'b0;

  function automatic logic [DW-1:0] sl_rd(input logic [AW-1:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Transaction-level expectation: accepted in cycle n, answered in cycle n+2+waits.
  task automatic model_accept(input xfer_t x);
    if (x.waits >= INF) begin
`ifdef APB_MASTER_TIMEOUT_EN
      exp_q.push_back({1'b1, {DW{1'b0}}});
      exp_cyc_q.push_back(cycle + 1 + TO);
`endif
    end else if (x.err) begin
      exp_q.push_back({1'b1, {DW{1'b0}}});
      exp_cyc_q.push_back(cycle + 2 + x.waits);
    end else if (x.wr) begin
      ref_mem[x.addr] = x.wdata;
      exp_q.push_back({1'b0, {DW{1'b0}}});
      exp_cyc_q.push_back(cycle + 2 + x.waits);
    end else begin
      exp_q.push_back({1'b0, ref_rd(x.addr)});
      exp_cyc_q.push_back(cycle + 2 + x.waits);
    end
  endtask

  task automatic monitor();
    logic [DW:0] e;
    int          c;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cycle) begin
      total++;
      bad++;
      $display("FAIL rsp_missing: no rsp_valid seen, required at cycle %0d (now %0d)", exp_cyc_q[0], cycle);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (bus.rsp_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: rsp_valid=1 err=%0b rdata=%h at cycle %0d, required none",
                 bus.rsp_err, bus.rsp_rdata, cycle);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        if ({bus.rsp_err, bus.rsp_rdata} !== e || c != cycle) begin
          bad++;
          $display("FAIL rsp_check: got err=%0b rdata=%h cycle=%0d, required err=%0b rdata=%h cycle=%0d",
                   bus.rsp_err, bus.rsp_rdata, cycle, e[DW], e[DW-1:0], c);
        end
      end
    end
  endtask

  task automatic slave();
    xfer_t x;
    if (sl_done) begin
      x = sl_q.pop_front();
      if (x.wr && !x.err) slave_mem[x.addr] = x.wdata;
      sl_done = 1'b0;
      sl_cnt  = 0;
    end
    if (bus.PSEL === 1'b1 && sl_q.size() > 0) begin
      x = sl_q[0];
      total++;
      if (bus.PADDR !== x.addr || bus.PWRITE !== x.wr || (x.wr && bus.PWDATA !== x.wdata)) begin
        bad++;
        $display("FAIL bus_cmd: got addr=%h wr=%0b wdata=%h, required addr=%h wr=%0b wdata=%h",
                 bus.PADDR, bus.PWRITE, bus.PWDATA, x.addr, x.wr, x.wdata);
      end
      if (bus.PENABLE === 1'b1) begin
        if (sl_cnt < x.waits) begin
          bus.PREADY  = 1'b0;
          bus.PSLVERR = 1'($urandom_range(0, 1));
          bus.PRDATA  = $urandom;
          sl_cnt++;
        end else begin
          bus.PREADY  = 1'b1;
          bus.PSLVERR = x.err;
          bus.PRDATA  = x.err ? 32'hFFFF_FFFF : (x.wr ? $urandom : sl_rd(x.addr));
          sl_done     = 1'b1;
        end
      end else begin
        bus.PREADY  = 1'($urandom_range(0, 1));
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA  = $urandom;
      end
    end else begin
      bus.PREADY  = 1'($urandom_range(0, 1));
      bus.PSLVERR = 1'($urandom_range(0, 1));
      bus.PRDATA  = $urandom;
    end
  endtask

  // One clock: note acceptance at the rising edge, observe and respond on the falling edge.
  task automatic step();
    xfer_t x;
    bit    acc;
    acc     = (bus.cmd_valid === 1'b1) && (bus.cmd_ready === 1'b1) && (PRESET === 1'b0);
    x.wr    = bus.cmd_write;
    x.addr  = bus.cmd_addr;
    x.wdata = bus.cmd_wdata;
    x.waits = d_waits;
    x.err   = d_err;
    @(posedge PCLK);
    cycle++;
    accepted = acc;
    if (acc) begin
      acc_cycle = cycle;
      sl_q.push_back(x);
      model_accept(x);
    end
    @(negedge PCLK);
    monitor();
    slave();
    tr_psel[cycle] = bus.PSEL;
    tr_pen[cycle]  = bus.PENABLE;
    #1;
  endtask

  task automatic flush_all();
    sl_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    sl_cnt  = 0;
    sl_done = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int waits, input logic err, input bit hold);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    d_waits       = waits;
    d_err         = err;
    for (int i = 0; i < 50; i++) begin
      step();
      if (accepted) break;
    end
    total++;
    if (!accepted) begin
      bad++;
      $display("FAIL accept_timeout: command addr=%h not accepted within 50 cycles", a);
    end
    if (!hold) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom_range(0, 1));
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
    end
  endtask

  task automatic drain();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    step();
    step();
    total++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
         bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: psel=%0b pen=%0b pwrite=%0b paddr=%h pwdata=%h rv=%0b rdata=%h err=%0b, required all 0",
               bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    total++;
    if (dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d, required IDLE", dbg_state);
    end
    PRESET = 1'b0;
    step();
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: cmd_ready=%0b, required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_single_write();
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    total++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101 || bus.PADDR !== 32'h10 || bus.PWDATA !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL write_setup: psel=%0b pen=%0b pwrite=%0b addr=%h wdata=%h, required 1 0 1 00000010 deadbeef",
               bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA);
    end
    step();
    total++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b11 || bus.PADDR !== 32'h10 || bus.PWDATA !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL write_access: psel=%0b pen=%0b addr=%h wdata=%h, required 1 1 00000010 deadbeef",
               bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA);
    end
    drain();
  endtask

  task automatic test_wait_read();
    int n;
    int pen_cnt;
    slave_mem[32'h20] = 32'h1234_5678;
    ref_mem[32'h20]   = 32'h1234_5678;
    issue(1'b0, 32'h20, $urandom, 2, 1'b0, 1'b0);
    n = acc_cycle;
    drain();
    pen_cnt = 0;
    for (int c = n; c <= n + 5; c++) if (tr_pen.exists(c) && tr_pen[c]) pen_cnt++;
    total++;
    if (pen_cnt != 3) begin
      bad++;
      $display("FAIL wait_access_len: ACCESS lasted %0d cycles, required 3", pen_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [3:0] sel_seq;
    logic [3:0] pen_seq;
    issue(1'b1, 32'h4, 32'hA5A5_A5A5, 0, 1'b0, 1'b1);
    n = acc_cycle;
    issue(1'b0, 32'h4, $urandom, 0, 1'b0, 1'b0);
    total++;
    if (acc_cycle != n + 2) begin
      bad++;
      $display("FAIL b2b_rate: second accept at cycle %0d, required %0d", acc_cycle, n + 2);
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      sel_seq[3-i] = tr_psel[n+i];
      pen_seq[3-i] = tr_pen[n+i];
    end
    total++;
    if (sel_seq !== 4'b1111 || pen_seq !== 4'b0101) begin
      bad++;
      $display("FAIL b2b_pattern: psel=%b penable=%b, required 1111 0101", sel_seq, pen_seq);
    end
  endtask

  task automatic test_slverr();
    slave_mem[32'h30] = 32'h0BAD_F00D;
    ref_mem[32'h30]   = 32'h0BAD_F00D;
    issue(1'b0, 32'h30, $urandom, 1, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_random();
    logic          wr;
    logic [AW-1:0] a;
    bit            hold;
    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = AW'($urandom_range(0, 7)) << 2;
      hold = 1'($urandom_range(0, 1));
      issue(wr, a, $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), hold);
      if (!hold) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) step();
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h40, $urandom, INF, 1'b0, 1'b0);
    step();
    PRESET = 1'b1;
    #1;
    total++;
    if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_async: psel=%0b pen=%0b rv=%0b, required 0 0 0",
               bus.PSEL, bus.PENABLE, bus.rsp_valid);
    end
    flush_all();
    step();
    step();
    PRESET = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (bus.cmd_ready !== 1'b1 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_mid_release: cmd_ready=%0b state=%0d, required 1 IDLE", bus.cmd_ready, dbg_state);
    end
  endtask

  task automatic test_timeout();
    int n;
    issue(1'b0, 32'h50, $urandom, INF, 1'b0, 1'b0);
    n = acc_cycle;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 20 && cycle < n + TO; i++) step();
    total++;
    if ({bus.PSEL, bus.PENABLE, bus.cmd_ready} !== 3'b110) begin
      bad++;
      $display("FAIL timeout_last_access: psel=%0b pen=%0b cmd_ready=%0b, required 1 1 0",
               bus.PSEL, bus.PENABLE, bus.cmd_ready);
    end
    step();
    total++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b00 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL timeout_idle: psel=%0b pen=%0b state=%0d, required 0 0 IDLE",
               bus.PSEL, bus.PENABLE, dbg_state);
    end
    drain();
    flush_all();
`else
    for (int i = 0; i < 100; i++) step();
    total++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b11 || dbg_state !== ACCESS) begin
      bad++;
      $display("FAIL no_timeout_wait: psel=%0b pen=%0b state=%0d after 100 cycles, required 1 1 ACCESS",
               bus.PSEL, bus.PENABLE, dbg_state);
    end
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    flush_all();
    step();
`endif
  endtask

  initial begin
    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    test_reset();
    test_single_write();
    test_wait_read();
    test_back_to_back();
    test_slverr();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
